param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 6, data word width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 64, number of storage words; power of two, 4..4096.
REQ-003 SHALL provide parameter AF_THRESH, default DEPTH-4; almost_full asserts when cnt >= AF_THRESH.
REQ-004 SHALL provide parameter AE_THRESH, default 4; almost_empty asserts when cnt <= AE_THRESH.
REQ-005 SHALL derive localparam CNT_W = log2(DEPTH)+1, so cnt spans 0..DEPTH.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 clr  input  1  synchronous flush: empties FIFO and clears sticky error flags.
REQ-009 din  input  DATA_W  write data, sampled when a write is accepted.
REQ-010 wr_en  input  1  write request.
REQ-011 rd_en  input  1  read request.
REQ-012 dout  output  DATA_W  registered read data.
REQ-013 dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-015 almost_full / almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-016 cnt  output  CNT_W  current occupancy.
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accepted iff wr_en=1 and full=0 in that cycle; din stored at write pointer, pointer advances modulo DEPTH.
REQ-019 Read accepted iff rd_en=1 and empty=0; head word presented on dout on the next rising edge with dout_valid=1 for exactly that cycle.
REQ-020 dout holds its last value when no read is accepted; dout_valid=0 in such cycles.
REQ-021 Full/empty acceptance uses the flags in the current cycle: with full=1 a simultaneous read is accepted but the write is rejected; with empty=1 a simultaneous write is accepted but the read is rejected.
REQ-022 cnt update: +1 write only, -1 read only, unchanged if both or neither accepted.
REQ-023 full, empty, almost_full, almost_empty are pure functions of the registered cnt, valid in the same cycle as cnt.
REQ-024 Pointers wrap from DEPTH-1 to 0 with no gap or duplicated word; data order strictly FIFO.
REQ-025 wr_en=1 while full=1 sets overflow on the next edge; rd_en=1 while empty=1 sets underflow; both stay set until rst or clr.
REQ-026 clr=1 on an edge: pointers and cnt to 0, overflow/underflow to 0, dout_valid to 0; wr_en/rd_en in that cycle ignored; dout retains value.
REQ-027 Memory contents are never reset; no output depends on unwritten locations.

Reset
REQ-028 On rst=1 at a rising edge: dout=0, dout_valid=0, cnt=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, pointers=0.
REQ-029 rst has priority over clr, wr_en, rd_en; reset mid-transfer discards all stored data, and the first post-reset read returns the first post-reset write.

Verification (bench overrides DATA_W=6, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-030 Fill: after reset write 0..7 on consecutive cycles -> cnt 1..8, almost_full at cnt=6, full at cnt=8, almost_empty drops at cnt=3, empty drops after first write.
REQ-031 Drain: from full, rd_en for 8 cycles -> dout 0..7 each one cycle after the read, dout_valid high 8 cycles, empty=1 with cnt=0 at end.
REQ-032 Wrap: write 5, read 5, then write 8 values 10..17 and read all -> dout 10..17 in order, no overflow/underflow.
REQ-033 Boundary: at full assert wr_en and rd_en with din=63 -> cnt 8->7, 63 not stored, overflow=1; at empty assert both -> cnt 0->1, underflow=1, no dout_valid.
REQ-034 Flush/reset: with cnt=5 and overflow=1 pulse clr -> cnt=0, empty=1, overflow=0 next cycle; repeat with rst mid-write -> all outputs at REQ-028 values, dout=0.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold
// flags and sticky overflow/underflow error flags.
module param_sync_fifo #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              full_r, empty_r, af_r, ae_r;
    logic              ovf_r, unf_r;
    logic              wr_ok_s, rd_ok_s;

    // Acceptance qualification and next occupancy; clr suppresses both requests.
    always_comb begin
        wr_ok_s    = 1'b0;
        rd_ok_s    = 1'b0;
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            wr_ok_s = wr_en & ~full_r;
            rd_ok_s = rd_en & ~empty_r;
            case ({wr_ok_s, rd_ok_s})
                2'b10:   cnt_next_s = cnt_r + ONE_C;
                2'b01:   cnt_next_s = cnt_r - ONE_C;
                default: cnt_next_s = cnt_r;
            endcase
        end
    end

    // Storage array: deliberately never reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, count and flags; flags are registered from the next count so
    // they always line up with cnt in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (clr) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                ovf_r    <= 1'b0;
                unf_r    <= 1'b0;
            end else begin
                if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                if (wr_en && full_r)  ovf_r <= 1'b1;
                if (rd_en && empty_r) unf_r <= 1'b1;
            end
            cnt_r   <= cnt_next_s;
            full_r  <= (cnt_next_s == DEPTH_C);
            empty_r <= (cnt_next_s == {CNT_W{1'b0}});
            af_r    <= (cnt_next_s >= AF_C);
            ae_r    <= (cnt_next_s <= AE_C);
        end
    end

    // Registered read port; dout holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (rd_ok_s) begin
            dout_r       <= mem_r[rd_ptr_r];
            dout_valid_r <= 1'b1;
        end else begin
            dout_valid_r <= 1'b0;
        end
    end

    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign cnt          = cnt_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (DATA_W=6, DEPTH=8,
// AF_THRESH=6, AE_THRESH=2) with hand-computed expectations.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst, clr, wr_en, rd_en;
    logic [5:0] din, dout;
    logic       dout_valid, full, empty, almost_full, almost_empty;
    logic [3:0] cnt;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    param_sync_fifo #(.DATA_W(6), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .cnt(cnt),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] v);
        wr_en = 1'b1;
        din   = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int unsigned exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_eq({tag, "_dout"}, dout, exp);
        check_eq({tag, "_valid"}, dout_valid, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_dout"}, dout, 0);
        check_eq({tag, "_valid"}, dout_valid, 0);
        check_eq({tag, "_cnt"}, cnt, 0);
        check_eq({tag, "_empty"}, empty, 1);
        check_eq({tag, "_ae"}, almost_empty, 1);
        check_eq({tag, "_full"}, full, 0);
        check_eq({tag, "_af"}, almost_full, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_unf"}, underflow, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 6'd0;
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        // Fill 0..7: af at 6, full at 8, ae while cnt<=2
        for (int i = 0; i < 8; i++) begin
            push(6'(i));
            check_eq("fill_cnt", cnt, i + 1);
            check_eq("fill_empty", empty, 0);
            check_eq("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
            check_eq("fill_full", full, (i + 1 == 8) ? 1 : 0);
            check_eq("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end

        // Drain back-to-back
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("drain_dout", dout, i);
            check_eq("drain_valid", dout_valid, 1);
            check_eq("drain_cnt", cnt, 7 - i);
        end
        rd_en = 1'b0;
        step();
        check_eq("idle_valid", dout_valid, 0);
        check_eq("idle_hold", dout, 7);
        check_eq("drain_empty", empty, 1);
        check_eq("drain_unf", underflow, 0);

        // Wrap: offset pointers by 5, then a full lap
        for (int i = 0; i < 5; i++) push(6'(20 + i));
        for (int i = 0; i < 5; i++) pop_check("wrap_pre", 20 + i);
        for (int i = 0; i < 8; i++) push(6'(10 + i));
        check_eq("wrap_full", full, 1);
        for (int i = 0; i < 8; i++) pop_check("wrap", 10 + i);
        check_eq("wrap_ovf", overflow, 0);
        check_eq("wrap_unf", underflow, 0);
        check_eq("wrap_empty", empty, 1);

        // Boundary at full: read accepted, write of 63 rejected
        for (int i = 0; i < 8; i++) push(6'(30 + i));
        wr_en = 1'b1; rd_en = 1'b1; din = 6'd63;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("bfull_cnt", cnt, 7);
        check_eq("bfull_ovf", overflow, 1);
        check_eq("bfull_dout", dout, 30);
        for (int i = 1; i < 8; i++) pop_check("bfull_drain", 30 + i);
        check_eq("bfull_empty", empty, 1);

        // Boundary at empty: write accepted, read rejected
        wr_en = 1'b1; rd_en = 1'b1; din = 6'd40;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("bempty_cnt", cnt, 1);
        check_eq("bempty_unf", underflow, 1);
        check_eq("bempty_valid", dout_valid, 0);
        check_eq("bempty_hold", dout, 37);
        pop_check("bempty_read", 40);

        // Flush with cnt=5 and overflow still set; requests in the clr cycle ignored
        for (int i = 0; i < 5; i++) push(6'(i + 1));
        check_eq("pre_clr_cnt", cnt, 5);
        check_eq("pre_clr_ovf", overflow, 1);
        clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 6'd9;
        step();
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_eq("clr_cnt", cnt, 0);
        check_eq("clr_empty", empty, 1);
        check_eq("clr_ovf", overflow, 0);
        check_eq("clr_unf", underflow, 0);
        check_eq("clr_valid", dout_valid, 0);
        check_eq("clr_hold", dout, 40);
        push(6'd44);
        pop_check("post_clr", 44);

        // Reset mid-write discards contents
        push(6'd50);
        push(6'd51);
        wr_en = 1'b1; din = 6'd52; rd_en = 1'b1;
        step();
        check_eq("pre_rst_dout", dout, 50);
        rst = 1'b1; din = 6'd53; rd_en = 1'b0;
        step();
        rst = 1'b0; wr_en = 1'b0;
        check_reset_state("midrst");
        push(6'd60);
        check_eq("postrst_cnt", cnt, 1);
        pop_check("postrst_first", 60);
        check_eq("postrst_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
